alu_wb_stage: RTL
=================

// Module: alu_wb_stage
// PURPOSE
//  Execute->writeback pipeline register sitting directly downstream of the ALU.
//  - Captures rslt/sc_o/pari/zero plus the destination tag and holds them in a
//    one-entry buffer until the register file accepts the write.
//  - Owns the architectural flag register (SC, PARI, ZERO). flag_sc feeds ALU sc_i.
//  - Counts retired instructions.
// PARAMETERS
//  DW    8   datapath width (ALU rslt width)
//  AW    3   register-file address width
//  CNTW  16  retire-counter width
// PORTS
//  clk          in   1     rising-edge clock
//  reset_n      in   1     asynchronous active-low reset
//  ex_valid     in   1     ALU result valid this cycle
//  ex_ready     out  1     stage can accept (combinational)
//  ex_rslt      in   DW    ALU rslt
//  ex_sc        in   1     ALU sc_o
//  ex_pari      in   1     ALU pari
//  ex_zero      in   1     ALU zero
//  ex_rf_we     in   1     instruction writes a register
//  ex_waddr     in   AW    destination register
//  ex_flag_we   in   1     instruction updates flags
//  wb_valid     out  1     pending register write
//  wb_ready     in   1     register file accepts write
//  wb_waddr     out  AW    write address
//  wb_wdata     out  DW    write data
//  flag_sc      out  1     stored carry/shift-out -> ALU sc_i
//  flag_pari    out  1     stored parity
//  flag_zero    out  1     stored zero
//  retire_cnt   out  CNTW  retired-instruction count
//  fwd_valid    out  1     forward entry valid (see CONFIGURATION)
//  fwd_addr     out  AW    forward address
//  fwd_data     out  DW    forward data
// BEHAVIOUR
//  Reset (async assert, sync deassert by the caller)
//  - Drives to 0: wb_valid, wb_waddr, wb_wdata, all flags, retire_cnt, fwd_*.
//  - A pending entry is discarded. No write is issued.
//  Handshake
//  - ex_ready = !wb_valid || wb_ready.
//  - Accept = ex_valid && ex_ready.
//  - Ex inputs must stay stable while ex_valid && !ex_ready.
//  Buffer states
//  - EMPTY -> FULL: on an accept with ex_rf_we=1. Latency 1 cycle to wb_valid.
//  - FULL -> EMPTY: on wb_ready with no accept.
//  - FULL -> FULL: on wb_ready with a simultaneous accept. The new entry is loaded, giving back-to-back throughput of 1 per cycle.
//  - While FULL and !wb_ready, wb_waddr and wb_wdata hold.
//  - An accept with ex_rf_we=0 does not allocate the buffer. It still retires and can still update the flags.
//  Flags
//  - On an accept with ex_flag_we=1, the flags are loaded from ex_sc, ex_pari and ex_zero in the same edge.
//  - The next ALU op sees the new flag_sc one cycle later.
//  - The flags are independent of wb_ready.
//  Retire counter
//  - Increments by 1 on every accept.
//  - Saturates at 2^CNTW-1. It does not wrap.
//  Widths
//  - wb_wdata = ex_rslt. No extension is applied.
// CONFIGURATION
//  ALU_WB_FWD_EN
//  - Defined: fwd_valid = wb_valid, fwd_addr = wb_waddr, fwd_data = wb_wdata.
//    Decode uses these to bypass a write that is stalled.
//  - Undefined: fwd_valid, fwd_addr and fwd_data are tied to 0. Decode must stall on a RAW hazard.
// STRUCTURE
//  - Shared package alu_pkg:
//    - typedef flags_t struct {sc, pari, zero}
//    - localparam DW_DEF = 8
//    - localparam AW_DEF = 3
//  - Sub-module sat_counter #(CNTW) holds the retire counter. The rest stays inline.
// TESTING
//  1. Reset mid-stall: FULL entry, wb_ready=0, pulse reset_n low
//     -> wb_valid=0, flags=0, retire_cnt=0, no write observed.
//  2. Single op: ex rslt=8'hAA, waddr=3, sc=1, flag_we=1, wb_ready=1
//     -> next cycle wb_valid=1, wdata=AA, waddr=3, flag_sc=1, retire_cnt=1.
//  3. Backpressure: entry FULL, wb_ready=0, new ex_valid
//     -> ex_ready=0, wb_wdata unchanged. Raise wb_ready -> simultaneous drain+load, no bubble.
//  4. Flag-only op: rf_we=0, flag_we=1, zero=1
//     -> wb_valid stays 0, flag_zero=1, retire_cnt increments.
//  5. Saturation: CNTW=4, 20 accepts -> retire_cnt stays 4'hF.
//  6. With ALU_WB_FWD_EN: stalled write to r5=8'h3C -> fwd_valid=1, fwd_addr=5, fwd_data=3C.
//     Without it -> all fwd_* are 0.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and defaults for the ALU writeback stage
package alu_pkg;

    localparam int DW_DEF = 8;
    localparam int AW_DEF = 3;

    // Architectural flag register contents.
    typedef struct packed {
        logic sc;
        logic pari;
        logic zero;
    } flags_t;

    // One-entry writeback buffer occupancy.
    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter
//
// Ports:
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset, clears the count
//   inc      in   add one this cycle (ignored once the count is all ones)
//   count    out  current count, CNTW bits
module sat_counter #(
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            inc,
    output logic [CNTW-1:0] count
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (inc && (count != {CNTW{1'b1}})) begin
            count <= count + CNTW'(1);
        end
    end

endmodule

// File: rtl/alu_wb_stage.sv
// rtl/alu_wb_stage.sv - execute-to-writeback register with flags and retire count
//
// Holds one ALU result until the register file accepts it, owns the
// architectural SC/PARI/ZERO flags and counts retired instructions.
// Optional macro ALU_WB_FWD_EN exposes the pending write on fwd_* for bypass;
// without it fwd_* are tied to zero.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   ex_valid/ex_ready            ALU result handshake (ex_ready combinational)
//   ex_rslt, ex_sc, ex_pari,
//   ex_zero                      ALU outputs
//   ex_rf_we, ex_waddr           register write enable and destination
//   ex_flag_we                   instruction updates the flags
//   wb_valid/wb_ready            register-file write handshake
//   wb_waddr, wb_wdata           pending write address and data
//   flag_sc, flag_pari,
//   flag_zero                    stored flags (flag_sc feeds ALU sc_i)
//   retire_cnt                   saturating retired-instruction count
//   fwd_valid, fwd_addr,
//   fwd_data                     bypass view of the pending write
module alu_wb_stage
    import alu_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int AW   = AW_DEF,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [DW-1:0]   ex_rslt,
    input  logic            ex_sc,
    input  logic            ex_pari,
    input  logic            ex_zero,
    input  logic            ex_rf_we,
    input  logic [AW-1:0]   ex_waddr,
    input  logic            ex_flag_we,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [AW-1:0]   wb_waddr,
    output logic [DW-1:0]   wb_wdata,
    output logic            flag_sc,
    output logic            flag_pari,
    output logic            flag_zero,
    output logic [CNTW-1:0] retire_cnt,
    output logic            fwd_valid,
    output logic [AW-1:0]   fwd_addr,
    output logic [DW-1:0]   fwd_data
);

    buf_state_t state;
    buf_state_t next_state;
    flags_t     flags;
    logic       accept;
    logic       load;

    // A draining entry frees the slot in the same cycle, so a full buffer
    // can still take a new result while the register file accepts the old one.
    assign ex_ready = (state == BUF_EMPTY) || wb_ready;
    assign accept   = ex_valid && ex_ready;
    assign load     = accept && ex_rf_we;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= BUF_EMPTY;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (load) begin
            next_state = BUF_FULL;
        end else if (wb_ready) begin
            next_state = BUF_EMPTY;
        end
    end

    // Payload only moves on a load, so a stalled write holds address and data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wb_waddr <= '0;
            wb_wdata <= '0;
        end else if (load) begin
            wb_waddr <= ex_waddr;
            wb_wdata <= ex_rslt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags <= '0;
        end else if (accept && ex_flag_we) begin
            flags <= '{sc: ex_sc, pari: ex_pari, zero: ex_zero};
        end
    end

    sat_counter #(
        .CNTW (CNTW)
    ) u_retire_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (accept),
        .count   (retire_cnt)
    );

    assign wb_valid  = (state == BUF_FULL);
    assign flag_sc   = flags.sc;
    assign flag_pari = flags.pari;
    assign flag_zero = flags.zero;

`ifdef ALU_WB_FWD_EN
    assign fwd_valid = wb_valid;
    assign fwd_addr  = wb_waddr;
    assign fwd_data  = wb_wdata;
`else
    assign fwd_valid = 1'b0;
    assign fwd_addr  = '0;
    assign fwd_data  = '0;
`endif

endmodule
